// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with valid/ready handshake
// and a two-entry skid buffer. The ready output comes straight from a flop,
// so downstream back-pressure never ripples combinationally upstream.
// Flushed or empty slots present CTRL_RST on the control field.
// Optional statistics counters are enabled with PIPE_STAGE_SKID_STATS_EN.
module pipe_stage_skid #(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 120,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_SKID_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    // Occupancy: main slot drives the outputs, skid slot holds overflow.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } occ_t;

    occ_t              state, state_nxt;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_nxt, s_ctrl, s_ctrl_nxt;
    logic [DATA_W-1:0] m_data, m_data_nxt, s_data, s_data_nxt;
    logic              in_rdy_q, in_rdy_nxt;
    logic              m_v, s_v;
    logic              acc, pop;

    assign m_v       = (state != EMPTY);
    assign s_v       = (state == FULL);
    assign in_ready  = in_rdy_q;
    assign acc       = in_valid & in_rdy_q;
    assign pop       = m_v & out_ready;
    assign out_valid = m_v;
    assign out_ctrl  = m_v ? m_ctrl : CTRL_RST;
    assign out_data  = m_data;

    // Next occupancy and slot contents; flush overrides every transition.
    always_comb begin
        state_nxt  = state;
        m_ctrl_nxt = m_ctrl;
        m_data_nxt = m_data;
        s_ctrl_nxt = s_ctrl;
        s_data_nxt = s_data;
        case (state)
            EMPTY: begin
                if (acc) begin
                    m_ctrl_nxt = in_ctrl;
                    m_data_nxt = in_data;
                    state_nxt  = ONE;
                end
            end
            ONE: begin
                if (pop && acc) begin
                    m_ctrl_nxt = in_ctrl;
                    m_data_nxt = in_data;
                end else if (pop) begin
                    state_nxt  = EMPTY;
                end else if (acc) begin
                    s_ctrl_nxt = in_ctrl;
                    s_data_nxt = in_data;
                    state_nxt  = FULL;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move things.
                if (pop) begin
                    m_ctrl_nxt = s_ctrl;
                    m_data_nxt = s_data;
                    state_nxt  = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt  = EMPTY;
            m_ctrl_nxt = '0;
            m_data_nxt = '0;
            s_ctrl_nxt = '0;
            s_data_nxt = '0;
        end
        in_rdy_nxt = (state_nxt != FULL);
    end

    // Occupancy, slot contents and registered ready, cleared by async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            m_ctrl   <= '0;
            m_data   <= '0;
            s_ctrl   <= '0;
            s_data   <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            m_ctrl   <= m_ctrl_nxt;
            m_data   <= m_data_nxt;
            s_ctrl   <= s_ctrl_nxt;
            s_data   <= s_data_nxt;
            in_rdy_q <= in_rdy_nxt;
        end
    end

`ifdef PIPE_STAGE_SKID_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating counts of stalled cycles and of flushes that discard entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (m_v && !out_ready) stall_cnt <= sat_inc(stall_cnt);
            if (flush && (m_v || s_v)) flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;
    localparam int             CW   = 8;
    localparam int             DW   = 120;
    localparam logic [CW-1:0]  CRST = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_SKID_STATS_EN
    logic [15:0]   stall_cnt, flush_cnt;
    int            stall_m, flush_m;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          q[$];
    logic [DW-1:0] last_d;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(CRST)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STAGE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_d = '0;
`ifdef PIPE_STAGE_SKID_STATS_EN
        stall_m = 0;
        flush_m = 0;
`endif
    endtask

    // Model: FIFO of at most two entries; ready means fewer than two held.
    task automatic model_update();
        int n;
        bit pop, acc;
        n   = q.size();
        pop = (n > 0) && out_ready;
        acc = in_valid && (n < 2);
`ifdef PIPE_STAGE_SKID_STATS_EN
        if (n > 0 && !out_ready && stall_m < 65535) stall_m++;
        if (flush && n > 0 && flush_m < 65535) flush_m++;
`endif
        if (flush) begin
            q.delete();
            last_d = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{c: in_ctrl, d: in_data});
            if (q.size() > 0) last_d = q[0].d;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [CW-1:0] exp_c;
        exp_c = (q.size() > 0) ? q[0].c : CRST;
        chk({tag, " out_valid"}, 128'(out_valid), 128'(q.size() > 0));
        chk({tag, " in_ready"},  128'(in_ready),  128'(q.size() < 2));
        chk({tag, " out_ctrl"},  128'(out_ctrl),  128'(exp_c));
        chk({tag, " out_data"},  128'(out_data),  128'(last_d));
`ifdef PIPE_STAGE_SKID_STATS_EN
        chk({tag, " stall_cnt"}, 128'(stall_cnt), 128'(stall_m));
        chk({tag, " flush_cnt"}, 128'(flush_cnt), 128'(flush_m));
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        // Reset state, checked between clock edges.
        #1 rst = 1'b0;
        #2;
        model_reset();
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst in_ready",  128'(in_ready),  128'(1));
        chk("rst out_ctrl",  128'(out_ctrl),  128'(CRST));
        chk("rst out_data",  128'(out_data),  128'(0));
        @(negedge clk);
        rst = 1'b1;

        // Stream 1..4 with downstream always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_ctrl = CW'(8'h10 + k);
            in_data = DW'(k);
            step("stream");
            chk("stream data", 128'(out_data), 128'(k));
            chk("stream valid", 128'(out_valid), 128'(1));
            chk("stream ready", 128'(in_ready), 128'(1));
        end

        // Bubbles after the stream drains: control zero, data retained.
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("bubble");
            chk("bubble ctrl", 128'(out_ctrl), 128'(8'h00));
            chk("bubble data", 128'(out_data), 128'(4));
        end

        // Back-pressure through the skid slot.
        in_valid = 1'b1; in_ctrl = 8'h21; in_data = DW'(5);
        step("bp load5");
        out_ready = 1'b0; in_ctrl = 8'h22; in_data = DW'(6);
        step("bp load6");
        chk("bp full ready", 128'(in_ready), 128'(0));
        in_ctrl = 8'h23; in_data = DW'(7);
        step("bp hold7");
        chk("bp head5", 128'(out_data), 128'(5));
        out_ready = 1'b1;
        step("bp pop5");
        chk("bp head6", 128'(out_data), 128'(6));
        step("bp pop6");
        chk("bp head7", 128'(out_data), 128'(7));
        chk("bp ctrl7", 128'(out_ctrl), 128'(8'h23));
        in_valid = 1'b0;
        step("bp drain");
        chk("bp empty", 128'(out_valid), 128'(0));

        // Flush while full, with an entry offered in the flush cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h21; in_data = DW'(5);
        step("fl load5");
        in_data = DW'(6);
        step("fl load6");
        flush = 1'b1; in_data = DW'(9);
        step("fl flush");
        chk("fl valid", 128'(out_valid), 128'(0));
        chk("fl ctrl",  128'(out_ctrl),  128'(CRST));
        chk("fl data",  128'(out_data),  128'(0));
        chk("fl ready", 128'(in_ready),  128'(1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step("fl after");
        chk("fl no9", 128'(out_valid), 128'(0));

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_ctrl   = CW'($urandom());
            in_data   = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
            step("rand");
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a cycle while full.
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h31; in_data = DW'(11);
        step("ar load1");
        in_data = DW'(12);
        step("ar load2");
        chk("ar full", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("ar out_valid", 128'(out_valid), 128'(0));
        chk("ar in_ready",  128'(in_ready),  128'(1));
        chk("ar out_ctrl",  128'(out_ctrl),  128'(CRST));
        chk("ar out_data",  128'(out_data),  128'(0));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'h41; in_data = DW'(120'hA);
        step("ar accept");
        chk("ar dataA", 128'(out_data), 128'(120'hA));
        chk("ar validA", 128'(out_valid), 128'(1));

`ifdef PIPE_STAGE_SKID_STATS_EN
        // Stall and flush counters from a fresh reset.
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step("st stall");
        chk("st stall5", 128'(stall_cnt), 128'(5));
        flush = 1'b1; out_ready = 1'b1;
        step("st flush");
        chk("st flush1", 128'(flush_cnt), 128'(1));
        chk("st stall_keep", 128'(stall_cnt), 128'(5));
        flush = 1'b0;
        step("st idle");
`endif

        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
